// File: rtl/serial_link_pkg.sv
// Shared types and default sizing for the serial link arbiter.
package serial_link_pkg;

  localparam int unsigned DefWidth = 8;
  localparam int unsigned DefNReq  = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/serial_link_arbiter_if.sv
// Requester bus and serial link signals of the arbiter, with arbiter (slave) and environment (master) views.
interface serial_link_arbiter_if #(
  parameter int unsigned width = serial_link_pkg::DefWidth,
  parameter int unsigned n_req = serial_link_pkg::DefNReq
);
  localparam int unsigned IdxW = $clog2(n_req);

  logic [n_req-1:0]       req_valid;
  logic [n_req*width-1:0] req_data;
  logic [n_req-1:0]       req_ready;
  logic                   serial_ready;
  logic                   serial_valid;
  logic                   serial_data;
  logic [IdxW-1:0]        grant_id;
  logic                   busy;

  modport slave (
    input  req_valid, req_data, serial_ready,
    output req_ready, serial_valid, serial_data, grant_id, busy
  );

  modport master (
    output req_valid, req_data, serial_ready,
    input  req_ready, serial_valid, serial_data, grant_id, busy
  );
endinterface

// File: rtl/serial_link_arbiter_rr.sv
// Requester arbiter: round-robin by default, fixed lowest-index priority
// when SERIAL_LINK_ARB_FIXED_PRIO_EN is defined.
module rr_arbiter #(
  parameter int unsigned n_req = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [n_req-1:0] req,
  input  logic             advance,
  output logic [n_req-1:0] grant
);

`ifdef SERIAL_LINK_ARB_FIXED_PRIO_EN
  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < n_req; i++) begin
      if (!found && req[i]) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end
`else
  localparam int unsigned IdxW = $clog2(n_req);

  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW-1:0] idx, win;
  logic            found;
  int unsigned     pos;

  // Search from the pointer upward, wrapping at n_req.
  always_comb begin
    grant = '0;
    found = 1'b0;
    pos   = 0;
    idx   = '0;
    win   = ptr_q;
    for (int unsigned i = 0; i < n_req; i++) begin
      pos = 32'(ptr_q) + i;
      if (pos >= n_req) pos = pos - n_req;
      idx = IdxW'(pos);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        win        = idx;
        found      = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance && found) begin
      ptr_d = (win == IdxW'(n_req - 1)) ? '0 : win + IdxW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
`endif

endmodule

// File: rtl/serial_link_arbiter.sv
// Arbitrates n_req word requesters onto a 1-bit LSB-first serial link.
// Define SERIAL_LINK_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module serial_link_arbiter
  import serial_link_pkg::*;
#(
  parameter int unsigned width = DefWidth,
  parameter int unsigned n_req = DefNReq
) (
  input logic                 clk,
  input logic                 rst,
  serial_link_arbiter_if.slave bus
);
  localparam int unsigned IdxW = $clog2(n_req);
  localparam int unsigned CntW = $clog2(width);

  state_e           state_q, state_d;
  logic [width-1:0] shreg_q, shreg_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [IdxW-1:0]  gid_q, gid_d;

  logic [n_req-1:0] grant;
  logic [width-1:0] win_word;
  logic [IdxW-1:0]  win_idx;
  logic             accept;
  logic             beat;

  assign accept = (state_q == IDLE) && (|bus.req_valid) && !rst;
  assign beat   = (state_q == SHIFT) && bus.serial_ready && !rst;

  rr_arbiter #(.n_req(n_req)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (bus.req_valid),
    .advance (accept),
    .grant   (grant)
  );

  // Select the winner's word and index from the one-hot grant.
  always_comb begin
    win_word = '0;
    win_idx  = '0;
    for (int unsigned i = 0; i < n_req; i++) begin
      if (grant[i]) begin
        win_word = bus.req_data[i*width +: width];
        win_idx  = IdxW'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    gid_d   = gid_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          shreg_d = win_word;
          gid_d   = win_idx;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (beat) begin
          shreg_d = shreg_q >> 1;
          cnt_d   = cnt_q + CntW'(1);
          if (cnt_q == CntW'(width - 1)) begin
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      gid_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      gid_q   <= gid_d;
    end
  end

  assign bus.req_ready    = accept ? grant : '0;
  assign bus.serial_valid = beat;
  assign bus.serial_data  = beat & shreg_q[0];
  assign bus.busy         = (state_q == SHIFT) && !rst;
  assign bus.grant_id     = gid_q;

endmodule

// File: tb/tb_serial_link_arbiter.sv
// Directed self-checking bench for serial_link_arbiter (width 8, four requesters).
module tb_serial_link_arbiter;
  logic clk;
  logic rst;
  int   errors;
  int   checks;

  serial_link_arbiter_if #(.width(8), .n_req(4)) bus ();

  serial_link_arbiter #(.width(8), .n_req(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic do_reset();
    rst              = 1'b1;
    bus.req_valid    = '0;
    bus.serial_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Waits for the grant to id, then deserializes its word off the link.
  task automatic run_word(input int id, input logic [7:0] exp_word, input bit drop, input bit toggle);
    bit         got;
    int         nb, first, last;
    logic [7:0] word;
    logic [3:0] exp_rdy;
    got = 1'b0; nb = 0; first = -1; last = -1; word = '0;
    exp_rdy = 4'(1 << id);
    bus.serial_ready = 1'b1;
    for (int w = 0; w < 20; w++) begin
      #1;
      if (bus.req_ready != 4'b0) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL grant_wait id%0d: req_ready stayed %b, required %b", id, bus.req_ready, exp_rdy);
      return;
    end else if (bus.req_ready !== exp_rdy) begin
      errors++;
      $display("FAIL grant id%0d: req_ready=%b required %b", id, bus.req_ready, exp_rdy);
    end
    @(posedge clk);
    #1;
    if (drop) begin
      bus.req_valid[id] = 1'b0;
      bus.req_data[id*8 +: 8] = ~exp_word;
    end
    for (int c = 0; c < 40 && nb < 8; c++) begin
      bus.serial_ready = toggle ? (c % 2 == 0) : 1'b1;
      #1;
      checks++;
      if (bus.serial_valid === 1'b1) begin
        if (nb == 0) first = c;
        word[nb] = bus.serial_data;
        if (bus.grant_id !== 2'(id) || bus.busy !== 1'b1) begin
          errors++;
          $display("FAIL beat id%0d: grant_id=%0d busy=%b required %0d,1", id, bus.grant_id, bus.busy, id);
        end
        nb++;
        if (nb == 8) last = c;
      end else if (bus.serial_data !== 1'b0 || bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL stall id%0d: serial_data=%b busy=%b required 0,1", id, bus.serial_data, bus.busy);
      end
      @(posedge clk);
      #1;
    end
    bus.serial_ready = 1'b1;
    #1;
    checks++;
    if (nb != 8 || word !== exp_word) begin
      errors++;
      $display("FAIL word id%0d: beats=%0d word=%h required 8 beats word=%h", id, nb, word, exp_word);
    end
    if (!toggle) begin
      checks++;
      if (first != 0 || last != 7) begin
        errors++;
        $display("FAIL latency id%0d: first=%0d last=%0d required 0,7", id, first, last);
      end
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.serial_valid !== 1'b0) begin
      errors++;
      $display("FAIL word_end id%0d: busy=%b serial_valid=%b required 0,0", id, bus.busy, bus.serial_valid);
    end
  endtask

  task automatic test_reset();
    rst              = 1'b1;
    bus.req_valid    = 4'b1111;
    bus.req_data     = 32'h4433_2211;
    bus.serial_ready = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0 || bus.serial_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_comb: req_ready=%b serial_valid=%b required 0000,0", bus.req_ready, bus.serial_valid);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.grant_id !== 2'd0 || bus.serial_valid !== 1'b0 ||
        bus.serial_data !== 1'b0 || bus.req_ready !== 4'b0) begin
      errors++;
      $display("FAIL reset_state: busy=%b gid=%0d sv=%b sd=%b rdy=%b required 0,0,0,0,0000",
               bus.busy, bus.grant_id, bus.serial_valid, bus.serial_data, bus.req_ready);
    end
    rst           = 1'b0;
    bus.req_valid = '0;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_req: req_ready=%b busy=%b required 0000,0", bus.req_ready, bus.busy);
    end
  endtask

  task automatic test_single();
    do_reset();
    bus.req_data[7:0] = 8'hA5;
    bus.req_valid     = 4'b0001;
    run_word(0, 8'hA5, 1'b1, 1'b0);
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.req_data[15:8] = 8'h3C;
    bus.req_valid      = 4'b0010;
    run_word(1, 8'h3C, 1'b1, 1'b1);
  endtask

  task automatic test_arbitration();
    do_reset();
    bus.req_data  = 32'h4433_2211;
    bus.req_valid = 4'b1111;
`ifdef SERIAL_LINK_ARB_FIXED_PRIO_EN
    for (int k = 0; k < 3; k++) run_word(0, 8'h11, 1'b0, 1'b0);
`else
    run_word(0, 8'h11, 1'b0, 1'b0);
    run_word(1, 8'h22, 1'b0, 1'b0);
    run_word(2, 8'h33, 1'b0, 1'b0);
    run_word(3, 8'h44, 1'b0, 1'b0);
    run_word(0, 8'h11, 1'b0, 1'b0);
`endif
    bus.req_valid = '0;
  endtask

  task automatic test_reset_mid_word();
    logic [7:0] w2;
    w2 = 8'h96;
    do_reset();
    bus.req_data[23:16] = w2;
    bus.req_data[15:8]  = 8'h5A;
    bus.req_valid       = 4'b0100;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL mid_grant: req_ready=%b required 0100", bus.req_ready);
    end
    @(posedge clk);
    #1;
    for (int b = 0; b < 3; b++) begin
      #1;
      checks++;
      if (bus.serial_valid !== 1'b1 || bus.serial_data !== w2[b]) begin
        errors++;
        $display("FAIL mid_beat%0d: sv=%b sd=%b required 1,%b", b, bus.serial_valid, bus.serial_data, w2[b]);
      end
      @(posedge clk);
      #1;
    end
    rst           = 1'b1;
    bus.req_valid = 4'b0110;
    #1;
    checks++;
    if (bus.serial_valid !== 1'b0 || bus.req_ready !== 4'b0) begin
      errors++;
      $display("FAIL mid_rst_cycle: sv=%b rdy=%b required 0,0000", bus.serial_valid, bus.req_ready);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (bus.serial_valid !== 1'b0 || bus.serial_data !== 1'b0 || bus.busy !== 1'b0 ||
        bus.grant_id !== 2'd0 || bus.req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL mid_after_rst: sv=%b sd=%b busy=%b gid=%0d rdy=%b required 0,0,0,0,0010",
               bus.serial_valid, bus.serial_data, bus.busy, bus.grant_id, bus.req_ready);
    end
    run_word(1, 8'h5A, 1'b1, 1'b0);
    run_word(2, w2, 1'b1, 1'b0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    test_reset();
    test_single();
    test_backpressure();
    test_arbitration();
    test_reset_mid_word();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1);
  end
endmodule
